// File: rtl/safe_access_controller.sv
// Safe access controller. It sits after the code comparator and drives the bolt,
// the lockout indicator, the alarm pulse and the fail indicators from enter/match/relock.
module safe_access_controller #(
    parameter int MAX_FAILS      = 3,
    parameter int FAIL_W         = 2,
    parameter int UNLOCK_CYCLES  = 8,
    parameter int LOCKOUT_CYCLES = 16,
    parameter int TIMER_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enter,
    input  logic              match,
    input  logic              relock,
    output logic              unlocked,
    output logic              locked_out,
    output logic              alarm,
    output logic              fail_pulse,
    output logic [FAIL_W-1:0] fail_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPEN    = 2'd1,
        LOCKOUT = 2'd2
    } state_e;

    localparam logic [TIMER_W-1:0] UNLOCK_LOAD  = TIMER_W'(UNLOCK_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);
    localparam logic [FAIL_W:0]    MAX_FAILS_X  = (FAIL_W+1)'(MAX_FAILS);

    state_e              state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [FAIL_W-1:0]   fail_count_q, fail_count_d;
    logic                unlocked_q, unlocked_d;
    logic                locked_out_q, locked_out_d;
    logic                alarm_q, alarm_d;
    logic                fail_pulse_q, fail_pulse_d;

    // One extra bit so the incremented count can never wrap before the compare.
    logic [FAIL_W:0]     fail_next;
    assign fail_next = {1'b0, fail_count_q} + (FAIL_W+1)'(1);

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        fail_count_d = fail_count_q;
        unlocked_d   = 1'b0;
        locked_out_d = 1'b0;
        alarm_d      = 1'b0;
        fail_pulse_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enter) begin
                    if (match) begin
                        state_d      = OPEN;
                        timer_d      = UNLOCK_LOAD;
                        fail_count_d = '0;
                        unlocked_d   = 1'b1;
                    end else if (fail_next >= MAX_FAILS_X) begin
                        state_d      = LOCKOUT;
                        timer_d      = LOCKOUT_LOAD;
                        fail_count_d = MAX_FAILS_X[FAIL_W-1:0];
                        fail_pulse_d = 1'b1;
                        alarm_d      = 1'b1;
                        locked_out_d = 1'b1;
                    end else begin
                        fail_count_d = fail_next[FAIL_W-1:0];
                        fail_pulse_d = 1'b1;
                    end
                end
            end
            OPEN: begin
                // enter is deliberately not looked at here; relock and expiry share one exit.
                if (timer_q == '0 || relock) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else begin
                    timer_d    = timer_q - TIMER_W'(1);
                    unlocked_d = 1'b1;
                end
            end
            LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d      = IDLE;
                    fail_count_d = '0;
                end else begin
                    timer_d      = timer_q - TIMER_W'(1);
                    locked_out_d = 1'b1;
                end
            end
            default: begin
                state_d      = IDLE;
                timer_d      = '0;
                fail_count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            fail_count_q <= '0;
            unlocked_q   <= 1'b0;
            locked_out_q <= 1'b0;
            alarm_q      <= 1'b0;
            fail_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            fail_count_q <= fail_count_d;
            unlocked_q   <= unlocked_d;
            locked_out_q <= locked_out_d;
            alarm_q      <= alarm_d;
            fail_pulse_q <= fail_pulse_d;
        end
    end

    assign unlocked   = unlocked_q;
    assign locked_out = locked_out_q;
    assign alarm      = alarm_q;
    assign fail_pulse = fail_pulse_q;
    assign fail_count = fail_count_q;

endmodule

// File: tb/tb_safe_access_controller.sv
// Bench for safe_access_controller: a table of one-cycle vectors with hand-computed outputs,
// plus hand-written async-reset sequences and a MAX_FAILS=1 / UNLOCK_CYCLES=1 instance.
module tb_safe_access_controller;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       enter = 1'b0, match = 1'b0, relock = 1'b0;
    logic       unlocked, locked_out, alarm, fail_pulse;
    logic [1:0] fail_count;

    logic       enter2 = 1'b0, match2 = 1'b0, relock2 = 1'b0;
    logic       unlocked2, locked_out2, alarm2, fail_pulse2;
    logic [0:0] fail_count2;

    safe_access_controller dut (
        .clk(clk), .rst_n(rst_n), .enter(enter), .match(match), .relock(relock),
        .unlocked(unlocked), .locked_out(locked_out), .alarm(alarm),
        .fail_pulse(fail_pulse), .fail_count(fail_count)
    );

    safe_access_controller #(
        .MAX_FAILS(1), .FAIL_W(1), .UNLOCK_CYCLES(1), .LOCKOUT_CYCLES(4), .TIMER_W(16)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .enter(enter2), .match(match2), .relock(relock2),
        .unlocked(unlocked2), .locked_out(locked_out2), .alarm(alarm2),
        .fail_pulse(fail_pulse2), .fail_count(fail_count2)
    );

    typedef struct {
        logic       e, m, r;
        logic       u, lo, al, fp;
        logic [1:0] fc;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(logic e, logic m, logic r, logic u, logic lo,
                                logic al, logic fp, logic [1:0] fc);
        vec_t v;
        v.e = e; v.m = m; v.r = r; v.u = u; v.lo = lo; v.al = al; v.fp = fp; v.fc = fc;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic e, input logic m, input logic r);
        @(negedge clk);
        enter = e; match = m; relock = r;
        @(posedge clk);
        #1;
    endtask

    task automatic step2(input logic e, input logic m);
        @(negedge clk);
        enter2 = e; match2 = m;
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic u, input logic lo, input logic al,
                        input logic fp, input int fc);
        chk({tag, ".unlocked"},   int'(unlocked),   int'(u));
        chk({tag, ".locked_out"}, int'(locked_out), int'(lo));
        chk({tag, ".alarm"},      int'(alarm),      int'(al));
        chk({tag, ".fail_pulse"}, int'(fail_pulse), int'(fp));
        chk({tag, ".fail_count"}, int'(fail_count), fc);
    endtask

    task automatic chk2(input string tag, input logic u, input logic lo, input logic al,
                        input logic fp, input int fc);
        chk({tag, ".unlocked"},   int'(unlocked2),   int'(u));
        chk({tag, ".locked_out"}, int'(locked_out2), int'(lo));
        chk({tag, ".alarm"},      int'(alarm2),      int'(al));
        chk({tag, ".fail_pulse"}, int'(fail_pulse2), int'(fp));
        chk({tag, ".fail_count"}, int'(fail_count2), fc);
    endtask

    initial begin
        // Two wrong entries, then a correct one; an ignored wrong entry mid-OPEN.
        add(0,0,0, 0,0,0,0,0);
        add(1,0,0, 0,0,0,1,1);
        add(0,0,0, 0,0,0,0,1);
        add(1,0,0, 0,0,0,1,2);
        add(1,1,0, 1,0,0,0,0);
        for (int i = 0; i < 7; i++) add(i == 2, 1'b0, 0, 1,0,0,0,0);
        add(0,0,0, 0,0,0,0,0);
        // Three wrong entries -> 16-cycle lockout; entries inside it are ignored.
        add(1,0,0, 0,0,0,1,1);
        add(1,0,0, 0,0,0,1,2);
        add(1,0,0, 0,1,1,1,3);
        for (int i = 0; i < 15; i++) add(i == 3 || i == 8, i == 3, i == 5, 0,1,0,0,3);
        add(1,1,0, 0,0,0,0,0);
        add(1,1,0, 1,0,0,0,0);
        // relock on the third OPEN cycle
        add(0,0,0, 1,0,0,0,0);
        add(0,0,0, 1,0,0,0,0);
        add(0,0,1, 0,0,0,0,0);
        add(0,0,0, 0,0,0,0,0);
        // relock coinciding with the final OPEN cycle, then held into IDLE
        add(1,1,0, 1,0,0,0,0);
        for (int i = 0; i < 7; i++) add(0,0,0, 1,0,0,0,0);
        add(0,0,1, 0,0,0,0,0);
        add(0,0,1, 0,0,0,0,0);
        add(1,1,0, 1,0,0,0,0);
        for (int i = 0; i < 7; i++) add(0,0,0, 1,0,0,0,0);
        add(0,0,0, 0,0,0,0,0);

        #1;
        chk1("reset_in", 0,0,0,0,0);
        chk2("reset_in2", 0,0,0,0,0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].e, tbl[i].m, tbl[i].r);
            chk1($sformatf("vec%0d", i), tbl[i].u, tbl[i].lo, tbl[i].al, tbl[i].fp,
                 int'(tbl[i].fc));
        end

        // Async reset mid-LOCKOUT with timer at 7.
        step(1,0,0); step(1,0,0); step(1,0,0);
        chk1("lk_entry", 0,1,1,1,3);
        for (int i = 0; i < 8; i++) step(0,0,0);
        chk1("lk_t7", 0,1,0,0,3);
        #2 rst_n = 1'b0;
        #1 chk1("async_rst_lk", 0,0,0,0,0);
        @(negedge clk); rst_n = 1'b1;
        step(1,1,0);
        chk1("open_after_rst", 1,0,0,0,0);

        // Async reset mid-OPEN.
        step(0,0,0); step(0,0,0);
        chk1("open_mid", 1,0,0,0,0);
        #2 rst_n = 1'b0;
        #1 chk1("async_rst_open", 0,0,0,0,0);
        @(negedge clk); rst_n = 1'b1;
        step(0,0,0);
        chk1("idle_after_rst", 0,0,0,0,0);
        step(1,1,0);
        chk1("open_after_rst2", 1,0,0,0,0);
        step(0,0,0);

        // MAX_FAILS=1, UNLOCK_CYCLES=1, LOCKOUT_CYCLES=4 instance.
        step2(1,0);
        chk2("m1_lock", 0,1,1,1,1);
        for (int i = 0; i < 3; i++) begin
            step2(i == 1, 1'b1);
            chk2($sformatf("m1_lk%0d", i), 0,1,0,0,1);
        end
        step2(0,0);
        chk2("m1_lk_end", 0,0,0,0,0);
        step2(1,1);
        chk2("m1_open", 1,0,0,0,0);
        step2(0,0);
        chk2("m1_close", 0,0,0,0,0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
